// File: rtl/frame_pkg.sv
// Shared constants and helpers for the frame assembler: index-width derivation
// and the saturating drop-counter limits.
package frame_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // A one-word frame still needs a one-bit index port.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// One-entry output holding register with a valid/ready handshake; a load is
// accepted whenever the slot is empty or being drained in the same cycle.
module frame_out_reg #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic [W-1:0] out_frame,
  output logic         out_valid,
  output logic         load_ok
);

  logic [W-1:0] frame_q, frame_d;
  logic         valid_q, valid_d;

  assign load_ok   = !valid_q || out_ready;
  assign out_frame = frame_q;
  assign out_valid = valid_q;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    frame_d = frame_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      frame_d = load_data;
      valid_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      valid_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/frame_assembler.sv
// Collects indexed receive words into a WORDS*WIDTH frame and commits it on the
// frame-done pulse. Define FRAME_ASM_ORDER_CHECK_EN to enforce in-order arrival.
module frame_assembler
  import frame_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int WORDS = 2,
  localparam int IDXW  = idx_width(WORDS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [IDXW-1:0]        in_index,
  input  logic                   in_sample,
  input  logic                   in_frame_done,
  output logic [WORDS*WIDTH-1:0] out_frame,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DROP_CNT_W-1:0]  drop_count,
  output logic                   err
);

  logic [WIDTH-1:0]       asm_q [WORDS];
  logic [WIDTH-1:0]       asm_d [WORDS];
  logic [WORDS-1:0]       mask_q, mask_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   err_q, err_d;
  logic                   idx_ok, load, load_ok, err_event, drop_event;
  logic [WORDS*WIDTH-1:0] load_data;
`ifdef FRAME_ASM_ORDER_CHECK_EN
  logic [IDXW:0]          exp_q, exp_d;
`endif

  assign idx_ok = int'(in_index) < WORDS;

  always_comb begin
    asm_d      = asm_q;
    mask_d     = mask_q;
    err_event  = 1'b0;
    drop_event = 1'b0;
    load       = 1'b0;
`ifdef FRAME_ASM_ORDER_CHECK_EN
    exp_d      = exp_q;
    if (in_sample) begin
      if (idx_ok && {1'b0, in_index} == exp_q) begin
        asm_d[in_index]  = in_data;
        mask_d[in_index] = 1'b1;
        exp_d            = exp_q + 1'b1;
      end else begin
        // Out-of-order word: discard the partial frame; index 0 starts a new one.
        err_event = 1'b1;
        mask_d    = '0;
        exp_d     = '0;
        if (in_index == '0) begin
          asm_d[0]  = in_data;
          mask_d[0] = 1'b1;
          exp_d     = 1;
        end
      end
    end
`else
    if (in_sample) begin
      if (idx_ok) begin
        asm_d[in_index]  = in_data;
        mask_d[in_index] = 1'b1;
      end else begin
        err_event = 1'b1;
      end
    end
`endif
    // The word sampled alongside the frame-done pulse is already merged above.
    if (in_frame_done) begin
      if (&mask_d && load_ok) begin
        load = 1'b1;
      end else begin
        drop_event = 1'b1;
        err_event  = 1'b1;
      end
      mask_d = '0;
`ifdef FRAME_ASM_ORDER_CHECK_EN
      exp_d  = '0;
`endif
    end
    drop_d = (drop_event && drop_q != DROP_CNT_MAX) ? drop_q + DROP_CNT_W'(1) : drop_q;
    err_d  = err_event;
  end

  always_comb begin
    load_data = '0;
    for (int w = 0; w < WORDS; w++) load_data[w*WIDTH +: WIDTH] = asm_d[w];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the assembly words are few, so they are reset like any other register.
      for (int w = 0; w < WORDS; w++) asm_q[w] <= '0;
      mask_q <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
`ifdef FRAME_ASM_ORDER_CHECK_EN
      exp_q  <= '0;
`endif
    end else begin
      for (int w = 0; w < WORDS; w++) asm_q[w] <= asm_d[w];
      mask_q <= mask_d;
      drop_q <= drop_d;
      err_q  <= err_d;
`ifdef FRAME_ASM_ORDER_CHECK_EN
      exp_q  <= exp_d;
`endif
    end
  end

  frame_out_reg #(.W(WORDS*WIDTH)) u_out_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .out_valid (out_valid),
    .load_ok   (load_ok)
  );

  assign drop_count = drop_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler: a word/frame-level model is stepped at
// each clock edge and compared with the DUT on every falling edge.
module tb_frame_assembler;

  localparam int WIDTH = 8;
  localparam int WORDS = 2;
  localparam int IDXW  = 1;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic [WIDTH-1:0]       in_data = '0;
  logic [IDXW-1:0]        in_index = '0;
  logic                   in_sample = 1'b0;
  logic                   in_frame_done = 1'b0;
  logic [WORDS*WIDTH-1:0] out_frame;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [7:0]             drop_count;
  logic                   err;

  int vectors = 0;
  int miscompares = 0;

  // Model state: words received so far, which slots are present, the held frame.
  logic [WIDTH-1:0]       m_word [WORDS];
  bit                     m_have [WORDS];
  int                     m_next;
  logic [WORDS*WIDTH-1:0] m_frame;
  bit                     m_valid;
  int                     m_drops;
  bit                     m_err;

  frame_assembler #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_index      (in_index),
    .in_sample     (in_sample),
    .in_frame_done (in_frame_done),
    .out_frame     (out_frame),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .drop_count    (drop_count),
    .err           (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < WORDS; w++) begin
      m_word[w] = '0;
      m_have[w] = 0;
    end
    m_next  = 0;
    m_frame = '0;
    m_valid = 0;
    m_drops = 0;
    m_err   = 0;
  endtask

  task automatic model_store(input int idx, input logic [WIDTH-1:0] d);
    m_word[idx] = d;
    m_have[idx] = 1;
  endtask

  // One clock edge of the model, using the inputs presented before that edge.
  task automatic model_step();
    bit error_seen;
    bit complete;
    int idx;
    error_seen = 0;
    idx = int'(in_index);
    if (in_sample) begin
`ifdef FRAME_ASM_ORDER_CHECK_EN
      if (idx < WORDS && idx == m_next) begin
        model_store(idx, in_data);
        m_next++;
      end else begin
        error_seen = 1;
        for (int w = 0; w < WORDS; w++) m_have[w] = 0;
        m_next = 0;
        if (idx == 0) begin
          model_store(0, in_data);
          m_next = 1;
        end
      end
`else
      if (idx < WORDS) model_store(idx, in_data);
      else error_seen = 1;
`endif
    end
    if (m_valid && out_ready) m_valid = 0;
    if (in_frame_done) begin
      complete = 1;
      for (int w = 0; w < WORDS; w++) if (!m_have[w]) complete = 0;
      // A frame fits only if the slot was empty or drained on this very edge.
      if (complete && !m_valid) begin
        for (int w = 0; w < WORDS; w++) m_frame[w*WIDTH +: WIDTH] = m_word[w];
        m_valid = 1;
      end else begin
        error_seen = 1;
        if (m_drops < 255) m_drops++;
      end
      for (int w = 0; w < WORDS; w++) m_have[w] = 0;
      m_next = 0;
    end
    m_err = error_seen;
  endtask

  task automatic cycle(input bit s, input int idx, input logic [WIDTH-1:0] d,
                       input bit done, input bit rdy);
    in_sample     = s;
    in_index      = IDXW'(idx);
    in_data       = d;
    in_frame_done = done;
    out_ready     = rdy;
    @(posedge clock);
    model_step();
    #1;
  endtask

  always @(negedge clock) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_frame", 32'(out_frame), 32'(m_frame));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("err", 32'(err), 32'(m_err));
  end

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_frame", 32'(out_frame), 32'h0);
    check("reset_drops", 32'(drop_count), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Basic two-word frame, consumed immediately.
    cycle(1, 0, 8'hA5, 0, 1);
    cycle(1, 1, 8'h76, 0, 1);
    cycle(0, 0, 8'h00, 1, 1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_frame", 32'(out_frame), 32'h76A5);
    cycle(0, 0, 8'h00, 0, 1);
    check("t1_drained", 32'(out_valid), 32'h0);
    check("t1_drops", 32'(drop_count), 32'h0);

    // Last word arrives in the same cycle as frame-done.
    cycle(1, 0, 8'h11, 0, 1);
    cycle(1, 1, 8'h22, 1, 1);
    check("t2_frame", 32'(out_frame), 32'h2211);
    check("t2_valid", 32'(out_valid), 32'h1);
    cycle(0, 0, 8'h00, 0, 1);

    // Incomplete frame is dropped with a single error pulse.
    cycle(1, 0, 8'h33, 0, 1);
    cycle(0, 0, 8'h00, 1, 1);
    check("t3_valid", 32'(out_valid), 32'h0);
    check("t3_drops", 32'(drop_count), 32'h1);
    check("t3_err", 32'(err), 32'h1);
    cycle(0, 0, 8'h00, 0, 1);
    check("t3_err_pulse", 32'(err), 32'h0);

    // Held frame blocks the next one, which is dropped; then it drains.
    cycle(1, 0, 8'h44, 0, 0);
    cycle(1, 1, 8'h55, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(1, 0, 8'h66, 0, 0);
    cycle(1, 1, 8'h77, 1, 0);
    check("t4_held", 32'(out_frame), 32'h5544);
    check("t4_drops", 32'(drop_count), 32'h2);
    check("t4_err", 32'(err), 32'h1);
    cycle(0, 0, 8'h00, 0, 1);
    check("t4_drained", 32'(out_valid), 32'h0);

    // Rewriting slot 0 keeps the latest word.
    cycle(1, 0, 8'h11, 0, 1);
    cycle(1, 0, 8'h22, 0, 1);
    cycle(1, 1, 8'h33, 1, 1);
    check("rewrite_frame", 32'(out_frame), 32'h3322);
    cycle(0, 0, 8'h00, 0, 1);

    // Index 1 before index 0, then a proper frame.
    cycle(1, 1, 8'h99, 0, 1);
`ifdef FRAME_ASM_ORDER_CHECK_EN
    check("t6_order_err", 32'(err), 32'h1);
`else
    check("t6_no_order_err", 32'(err), 32'h0);
`endif
    cycle(1, 0, 8'h88, 0, 1);
    cycle(1, 1, 8'h99, 0, 1);
    cycle(0, 0, 8'h00, 1, 1);
    check("t6_frame", 32'(out_frame), 32'h9988);
    check("t6_valid", 32'(out_valid), 32'h1);
    cycle(0, 0, 8'h00, 0, 1);

    // Saturate the drop counter with empty frames.
    for (int n = 0; n < 260; n++) cycle(0, 0, 8'h00, 1, 1);
    check("t5_saturated", 32'(drop_count), 32'hFF);

    // Reset in the middle of a frame.
    cycle(1, 0, 8'h5A, 0, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_frame", 32'(out_frame), 32'h0);
    check("t5_rst_drops", 32'(drop_count), 32'h0);
    check("t5_rst_err", 32'(err), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // The partial word is gone: a lone index 1 cannot complete the frame.
    cycle(1, 1, 8'hC3, 0, 1);
    cycle(0, 0, 8'h00, 1, 1);
    check("post_rst_drop", 32'(drop_count), 32'h1);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    cycle(0, 0, 8'h00, 0, 1);
    @(negedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
